// File: rtl/ps2_key_tracker_if.sv
// Signal bundle between a PS/2 keyboard port and the key tracker.
// The slave modport is the tracker; the master side drives the raw lines and observes decoded state.
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 7
);
    logic                PS2_CLK;
    logic                PS2_DAT;
    logic [NUM_KEYS-1:0] key_held;
    logic                code_valid;
    logic [7:0]          code_out;
    logic                code_ext;
    logic                code_break;
    logic                frame_err;
    logic [7:0]          err_count;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  key_held, code_valid, code_out, code_ext, code_break, frame_err, err_count
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output key_held, code_valid, code_out, code_ext, code_break, frame_err, err_count
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver with E0/F0 prefix resolution and a held/released bit per mapped key.
// Optional macro PS2_KEY_TRACKER_HOTPLUG_CLR_EN: clear all held keys on BAT-pass (AA) or any frame error.
module ps2_key_tracker #(
    parameter int NUM_KEYS       = 7,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter logic [NUM_KEYS*9-1:0] KEY_MAP =
        {9'h01D, 9'h01B, 9'h175, 9'h172, 9'h012, 9'h014, 9'h058}
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    ps2_key_tracker_if.slave  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]      FLT_LAST = 5'(FILTER_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic                clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic                filt_clk_q, filt_clk_d;
    logic [4:0]          flt_cnt_q, flt_cnt_d;
    logic                strobe;
    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                accept, err;
    logic                ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic                code_valid_q, code_valid_d, frame_err_q, frame_err_d;
    logic [7:0]          code_out_q, code_out_d, err_count_q, err_count_d;
    logic                code_ext_q, code_ext_d, code_break_q, code_break_d;
    logic [NUM_KEYS-1:0] key_held_q, key_held_d, key_hit;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_clk_q   <= 1'b1;
            flt_cnt_q    <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            to_cnt_q     <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            code_out_q   <= '0;
            code_ext_q   <= 1'b0;
            code_break_q <= 1'b0;
            err_count_q  <= '0;
            key_held_q   <= '0;
        end else begin
            clk_s1_q     <= bus.PS2_CLK;
            clk_s2_q     <= clk_s1_q;
            dat_s1_q     <= bus.PS2_DAT;
            dat_s2_q     <= dat_s1_q;
            filt_clk_q   <= filt_clk_d;
            flt_cnt_q    <= flt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            to_cnt_q     <= to_cnt_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            code_out_q   <= code_out_d;
            code_ext_q   <= code_ext_d;
            code_break_q <= code_break_d;
            err_count_q  <= err_count_d;
            key_held_q   <= key_held_d;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        flt_cnt_d  = '0;
        filt_clk_d = filt_clk_q;
        strobe     = 1'b0;
        if (clk_s2_q != filt_clk_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                filt_clk_d = clk_s2_q;
                strobe     = filt_clk_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 5'd1;
            end
        end
    end

    // Frame FSM; a stall inside a frame takes priority over any pending strobe.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        to_cnt_d  = to_cnt_q;
        accept    = 1'b0;
        err       = 1'b0;
        if (state_q != S_IDLE && to_cnt_q >= TO_LIM) begin
            err       = 1'b1;
            state_d   = S_IDLE;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
        end else begin
            if (state_q != S_IDLE)
                to_cnt_d = strobe ? '0 : to_cnt_q + TO_W'(1);
            if (strobe) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                            to_cnt_d  = '0;
                        end
                    end
                    S_DATA: begin
                        shift_d   = {dat_s2_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_d = S_PARITY;
                    end
                    S_PARITY: begin
                        par_ok_d = ^{shift_q, dat_s2_q};
                        state_d  = S_STOP;
                    end
                    default: begin
                        state_d  = S_IDLE;
                        to_cnt_d = '0;
                        if (dat_s2_q && par_ok_q)
                            accept = 1'b1;
                        else
                            err = 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_hit
        assign key_hit[gi] = (KEY_MAP[9*gi +: 9] == {ext_pend_q, shift_q});
    end

    always_comb begin
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        code_out_d   = code_out_q;
        code_ext_d   = code_ext_q;
        code_break_d = code_break_q;
        err_count_d  = err_count_q;
        key_held_d   = key_held_q;
        if (err) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            if (err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
`ifdef PS2_KEY_TRACKER_HOTPLUG_CLR_EN
            key_held_d = '0;
`endif
        end else if (accept) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_out_d   = shift_q;
                code_ext_d   = ext_pend_q;
                code_break_d = brk_pend_q;
                ext_pend_d   = 1'b0;
                brk_pend_d   = 1'b0;
                key_held_d   = (key_held_q & ~key_hit) | (brk_pend_q ? '0 : key_hit);
`ifdef PS2_KEY_TRACKER_HOTPLUG_CLR_EN
                if (shift_q == 8'hAA && !ext_pend_q && !brk_pend_q)
                    key_held_d = '0;
`endif
            end
        end
    end

    assign bus.key_held   = key_held_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code_out   = code_out_q;
    assign bus.code_ext   = code_ext_q;
    assign bus.code_break = code_break_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: a reference model queues expected events as frames are
// driven; a monitor captures DUT events which each test pops and compares.
module tb_ps2_key_tracker;
    localparam int HALF    = 11;
    localparam int TIMEOUT = 1000;
    localparam logic [8:0] KM [0:6] = '{9'h058, 9'h014, 9'h012, 9'h172, 9'h175, 9'h01B, 9'h01D};

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [6:0] held;
        logic [7:0] errs;
    } ev_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    logic [6:0] m_held;
    logic [7:0] m_code, m_errs;
    logic       m_ext, m_brk, m_cext, m_cbrk;

    ps2_key_tracker_if #(.NUM_KEYS(7)) bus ();

    ps2_key_tracker #(
        .NUM_KEYS(7), .FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (!reset && (bus.code_valid || bus.frame_err))
            obs_q.push_back({bus.code_valid, bus.frame_err, bus.code_out, bus.code_ext,
                             bus.code_break, bus.key_held, bus.err_count});
    end

    task automatic model_reset();
        m_held = '0; m_code = '0; m_errs = '0;
        m_ext = 0; m_brk = 0; m_cext = 0; m_cbrk = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 7; i++)
                if (KM[i] == {m_ext, b}) m_held[i] = ~m_brk;
`ifdef PS2_KEY_TRACKER_HOTPLUG_CLR_EN
            if (b == 8'hAA && !m_ext && !m_brk) m_held = '0;
`endif
            m_code = b; m_cext = m_ext; m_cbrk = m_brk;
            exp_q.push_back({1'b1, 1'b0, m_code, m_cext, m_cbrk, m_held, m_errs});
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0; m_brk = 0;
        if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
`ifdef PS2_KEY_TRACKER_HOTPLUG_CLR_EN
        m_held = '0;
`endif
        exp_q.push_back({1'b0, 1'b1, m_code, m_cext, m_cbrk, m_held, m_errs});
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 = start) on the raw lines.
    task automatic send_bits(input logic [10:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.PS2_DAT = v[i];
            repeat (HALF) @(negedge CLOCK_50);
            bus.PS2_CLK = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            bus.PS2_CLK = 1'b1;
        end
        bus.PS2_DAT = 1'b1;
        repeat (20) @(negedge CLOCK_50);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_accept(b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic get_ev(output ev_t o, output bit ok);
        int n;
        ok = 0; o = '0; n = 0;
        while (!ok && n < 3 * TIMEOUT) begin
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                ok = 1;
            end else begin
                @(negedge CLOCK_50);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 7;
        if (bus.key_held !== 7'h00)   begin miscompares++; $display("FAIL reset_held: got %h want 00", bus.key_held); end
        if (bus.code_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.code_valid); end
        if (bus.code_out !== 8'h00)   begin miscompares++; $display("FAIL reset_code: got %h want 00", bus.code_out); end
        if (bus.code_ext !== 1'b0)    begin miscompares++; $display("FAIL reset_ext: got %b want 0", bus.code_ext); end
        if (bus.code_break !== 1'b0)  begin miscompares++; $display("FAIL reset_brk: got %b want 0", bus.code_break); end
        if (bus.frame_err !== 1'b0)   begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        if (bus.err_count !== 8'h00)  begin miscompares++; $display("FAIL reset_errcnt: got %h want 00", bus.err_count); end
        $display("reset: held=%b code=%h errcnt=%0d", bus.key_held, bus.code_out, bus.err_count);
    endtask

    task automatic test_make_break();
        ev_t o, e; bit ok;
        send_byte(8'h1D);
        send_byte(8'hF0); send_byte(8'h1D);
        while (exp_q.size() > 0) begin
            get_ev(o, ok); e = exp_q.pop_front(); vectors++;
            if (!ok || o !== e) begin miscompares++; $display("FAIL make_break: got %h want %h ok=%0d", o, e, ok); end
            else $display("make_break: code=%h ext=%b brk=%b held=%b", o.code, o.ext, o.brk, o.held);
        end
    endtask

    task automatic test_extended();
        ev_t o, e; bit ok;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'h1D);
        send_byte(8'h75);
        send_byte(8'h1D);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        while (exp_q.size() > 0) begin
            get_ev(o, ok); e = exp_q.pop_front(); vectors++;
            if (!ok || o !== e) begin miscompares++; $display("FAIL extended: got %h want %h ok=%0d", o, e, ok); end
            else $display("extended: code=%h ext=%b brk=%b held=%b", o.code, o.ext, o.brk, o.held);
        end
    endtask

    task automatic test_parity_err();
        ev_t o, e; bit ok;
        for (int k = 0; k < 256; k++) begin
            model_err();
            send_frame(8'h1D, 1'b1, 1'b0);
            get_ev(o, ok); e = exp_q.pop_front(); vectors++;
            if (!ok || o !== e) begin miscompares++; $display("FAIL parity_err[%0d]: got %h want %h ok=%0d", k, o, e, ok); end
            else if (k == 0 || k >= 254) $display("parity_err[%0d]: errcnt=%0d held=%b", k, o.errs, o.held);
        end
        model_err();
        send_frame(8'h1B, 1'b0, 1'b1);
        get_ev(o, ok); e = exp_q.pop_front(); vectors++;
        if (!ok || o !== e) begin miscompares++; $display("FAIL stop_err: got %h want %h ok=%0d", o, e, ok); end
        else $display("stop_err: errcnt=%0d", o.errs);
    endtask

    task automatic test_timeout();
        ev_t o, e; bit ok;
        do_reset();
        model_err();
        send_bits({1'b1, ~^8'h1D, 8'h1D, 1'b0}, 5);
        get_ev(o, ok); e = exp_q.pop_front(); vectors++;
        if (!ok || o !== e) begin miscompares++; $display("FAIL timeout_err: got %h want %h ok=%0d", o, e, ok); end
        else $display("timeout: errcnt=%0d", o.errs);
        repeat (2 * TIMEOUT) @(negedge CLOCK_50);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL timeout_once: got %0d extra events want 0", obs_q.size()); end
        send_byte(8'h14);
        get_ev(o, ok); e = exp_q.pop_front(); vectors++;
        if (!ok || o !== e) begin miscompares++; $display("FAIL after_timeout: got %h want %h ok=%0d", o, e, ok); end
        else $display("after_timeout: code=%h held=%b", o.code, o.held);
    endtask

    task automatic test_glitch_reset();
        do_reset();
        bus.PS2_CLK = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        bus.PS2_CLK = 1'b1;
        repeat (50) @(negedge CLOCK_50);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL glitch: got %0d events want 0", obs_q.size()); end
        else $display("glitch: no events");
        send_bits({1'b1, ~^8'h1D, 8'h1D, 1'b0}, 5);
        do_reset();
        repeat (2 * TIMEOUT) @(negedge CLOCK_50);
        vectors += 3;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL midframe_reset_events: got %0d want 0", obs_q.size()); end
        if (bus.err_count !== 8'h00) begin miscompares++; $display("FAIL midframe_reset_errcnt: got %h want 00", bus.err_count); end
        if (bus.key_held !== 7'h00 || bus.code_out !== 8'h00) begin
            miscompares++; $display("FAIL midframe_reset_out: got held=%h code=%h want 00 00", bus.key_held, bus.code_out);
        end
        $display("midframe_reset: errcnt=%0d held=%b", bus.err_count, bus.key_held);
    endtask

    task automatic test_hotplug();
        ev_t o, e; bit ok;
        do_reset();
        send_byte(8'h1D); send_byte(8'h12); send_byte(8'hAA);
        while (exp_q.size() > 0) begin
            get_ev(o, ok); e = exp_q.pop_front(); vectors++;
            if (!ok || o !== e) begin miscompares++; $display("FAIL hotplug: got %h want %h ok=%0d", o, e, ok); end
            else $display("hotplug: code=%h held=%b", o.code, o.held);
        end
    endtask

    initial begin
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        model_reset();
        test_reset();
        test_make_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_glitch_reset();
        test_hotplug();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
